// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP receiver: FSM states, error codes,
// header byte offsets and the debug view.
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_END     = 3'd4
  } udp_state_e;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_PORT    = 3'd1;
  localparam logic [2:0] ERR_LEN_BAD = 3'd2;
  localparam logic [2:0] ERR_TRUNC   = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  localparam logic [2:0] OFF_SRC_HI  = 3'd0;
  localparam logic [2:0] OFF_SRC_LO  = 3'd1;
  localparam logic [2:0] OFF_DST_HI  = 3'd2;
  localparam logic [2:0] OFF_DST_LO  = 3'd3;
  localparam logic [2:0] OFF_LEN_HI  = 3'd4;
  localparam logic [2:0] OFF_LEN_LO  = 3'd5;
  localparam logic [2:0] OFF_CSUM_HI = 3'd6;
  localparam logic [2:0] OFF_CSUM_LO = 3'd7;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  typedef struct packed {
    udp_state_e  state;
    logic [15:0] csum;
  } udp_dbg_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_receiver.sv
// UDP datagram receiver: parses the 8-byte header, forwards the payload one
// cycle after sampling, and reports a status code with a pkt_done pulse.
module udp_receiver
  import udp_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT = 16'd5001,
  parameter int          CHECK_PORT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  udp_data,
  input  logic        udp_valid,
  output logic [15:0] src_port,
  output logic [15:0] udp_len,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        pkt_done,
  output logic [2:0]  err_code,
  output udp_dbg_t    dbg
);

  udp_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] csum_q, csum_d;
  logic [2:0]  err_q, err_d;
  logic        sync_q, sync_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [7:0]  payload_data_q, payload_data_d;
  logic        payload_valid_q, payload_valid_d;
  logic        payload_last_q, payload_last_d;
  logic        pkt_done_q, pkt_done_d;
  logic [2:0]  err_code_q, err_code_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dst_d           = dst_q;
    csum_d          = csum_q;
    err_d           = err_q;
    sync_d          = sync_q;
    src_port_d      = src_port_q;
    udp_len_d       = udp_len_q;
    payload_data_d  = payload_data_q;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    pkt_done_d      = 1'b0;
    err_code_d      = err_code_q;

    case (state_q)
      ST_IDLE: begin
        // sync_q stays low after reset until udp_valid is seen low, so the
        // tail of an interrupted datagram is never mistaken for a header.
        if (!udp_valid) begin
          sync_d = 1'b1;
        end else if (sync_q) begin
          src_port_d = {udp_data, src_port_q[7:0]};
          cnt_d      = 16'd1;
          err_d      = ERR_OK;
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        if (!udp_valid) begin
          pkt_done_d = 1'b1;
          err_code_d = ERR_TRUNC;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
          case (cnt_q[2:0])
            OFF_SRC_LO:  src_port_d[7:0]  = udp_data;
            OFF_DST_HI:  dst_d[15:8]      = udp_data;
            OFF_DST_LO:  dst_d[7:0]       = udp_data;
            OFF_LEN_HI:  udp_len_d[15:8]  = udp_data;
            OFF_LEN_LO:  udp_len_d[7:0]   = udp_data;
            OFF_CSUM_HI: csum_d[15:8]     = udp_data;
            default:     csum_d[7:0]      = udp_data;
          endcase
          // Length and destination are complete before the last checksum byte.
          if (cnt_q[2:0] == OFF_CSUM_LO) begin
            if (udp_len_q < UDP_HDR_LEN) begin
              err_d   = ERR_LEN_BAD;
              state_d = ST_DROP;
            end else if ((CHECK_PORT != 0) && (dst_q != LOCAL_PORT)) begin
              err_d   = ERR_PORT;
              state_d = ST_DROP;
            end else if (udp_len_q == UDP_HDR_LEN) begin
              state_d = ST_END;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (!udp_valid) begin
          pkt_done_d = 1'b1;
          err_code_d = ERR_TRUNC;
          state_d    = ST_IDLE;
        end else begin
          cnt_d           = sat_inc(cnt_q);
          payload_data_d  = udp_data;
          payload_valid_d = 1'b1;
          if (cnt_q == udp_len_q - 16'd1) begin
            payload_last_d = 1'b1;
            state_d        = ST_END;
          end
        end
      end

      ST_DROP: begin
        if (!udp_valid) begin
          pkt_done_d = 1'b1;
          err_code_d = err_q;
          state_d    = ST_IDLE;
        end
      end

      ST_END: begin
        if (!udp_valid) begin
          pkt_done_d = 1'b1;
          err_code_d = err_q;
          state_d    = ST_IDLE;
        end else if (err_q == ERR_OK) begin
          err_d = ERR_OVERRUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 16'd0;
      dst_q           <= 16'd0;
      csum_q          <= 16'd0;
      err_q           <= ERR_OK;
      sync_q          <= 1'b0;
      src_port_q      <= 16'd0;
      udp_len_q       <= 16'd0;
      payload_data_q  <= 8'd0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      pkt_done_q      <= 1'b0;
      err_code_q      <= ERR_OK;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dst_q           <= dst_d;
      csum_q          <= csum_d;
      err_q           <= err_d;
      sync_q          <= sync_d;
      src_port_q      <= src_port_d;
      udp_len_q       <= udp_len_d;
      payload_data_q  <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      payload_last_q  <= payload_last_d;
      pkt_done_q      <= pkt_done_d;
      err_code_q      <= err_code_d;
    end
  end

  assign src_port      = src_port_q;
  assign udp_len       = udp_len_q;
  assign payload_data  = payload_data_q;
  assign payload_valid = payload_valid_q;
  assign payload_last  = payload_last_q;
  assign pkt_done      = pkt_done_q;
  assign err_code      = err_code_q;
  assign dbg           = '{state: state_q, csum: csum_q};

endmodule

// File: tb/tb_udp_receiver.sv
// Scoreboard bench for udp_receiver: directed datagrams on a port-checking
// instance and a port-agnostic instance, checked by a negedge monitor.
module tb_udp_receiver;
  import udp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din [2];
  logic        vin [2];
  logic [15:0] src_o [2];
  logic [15:0] len_o [2];
  logic [7:0]  pd_o [2];
  logic        pv_o [2];
  logic        pl_o [2];
  logic        done_o [2];
  logic [2:0]  err_o [2];
  udp_dbg_t    dbg_o [2];

  // Expected entries carry the instance index in the MSB; the two instances
  // never carry traffic at the same time, so one ordered queue serves both.
  logic [9:0]  exp_pay_q [$];
  logic [35:0] exp_done_q [$];
  logic [7:0]  pkt [$];
  int          checks = 0;
  int          errors = 0;
  logic        chk_rst = 1'b0;
  logic        fin = 1'b0;

  always #5 clk = ~clk;

  udp_receiver #(.LOCAL_PORT(16'd5001), .CHECK_PORT(1)) dut (
    .clk(clk), .rst_n(rst_n), .udp_data(din[0]), .udp_valid(vin[0]),
    .src_port(src_o[0]), .udp_len(len_o[0]), .payload_data(pd_o[0]),
    .payload_valid(pv_o[0]), .payload_last(pl_o[0]), .pkt_done(done_o[0]),
    .err_code(err_o[0]), .dbg(dbg_o[0])
  );

  udp_receiver #(.LOCAL_PORT(16'd5001), .CHECK_PORT(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .udp_data(din[1]), .udp_valid(vin[1]),
    .src_port(src_o[1]), .udp_len(len_o[1]), .payload_data(pd_o[1]),
    .payload_valid(pv_o[1]), .payload_last(pl_o[1]), .pkt_done(done_o[1]),
    .err_code(err_o[1]), .dbg(dbg_o[1])
  );

  task automatic hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    pkt.delete();
    pkt.push_back(s[15:8]); pkt.push_back(s[7:0]);
    pkt.push_back(d[15:8]); pkt.push_back(d[7:0]);
    pkt.push_back(l[15:8]); pkt.push_back(l[7:0]);
    pkt.push_back(8'h00);   pkt.push_back(8'h00);
  endtask

  task automatic add_str(input string str, input int n);
    for (int i = 0; i < n; i++) pkt.push_back(str[i]);
  endtask

  task automatic exp_pay(input int sel, input string str, input int n, input bit last_end);
    logic       lb;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      lb = last_end && (i == n - 1);
      b  = str[i];
      exp_pay_q.push_back({sel[0], lb, b});
    end
  endtask

  task automatic exp_done(input int sel, input logic [2:0] e, input logic [15:0] s,
                          input logic [15:0] l);
    exp_done_q.push_back({sel[0], e, s, l});
  endtask

  task automatic send(input int sel, input int gap);
    foreach (pkt[i]) begin
      din[sel] = pkt[i];
      vin[sel] = 1'b1;
      @(posedge clk); #1;
    end
    vin[sel] = 1'b0;
    din[sel] = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    logic [9:0]  ep;
    logic [35:0] ed;
    for (int i = 0; i < 2; i++) begin
      if (chk_rst) begin
        checks++;
        if ({src_o[i], len_o[i], pd_o[i], pv_o[i], pl_o[i], done_o[i], err_o[i]} !== 46'd0) begin
          errors++;
          $display("FAIL reset_outs%0d: got src=%h len=%h pd=%h pv=%b pl=%b done=%b err=%0d, want all 0",
                   i, src_o[i], len_o[i], pd_o[i], pv_o[i], pl_o[i], done_o[i], err_o[i]);
        end
        checks++;
        if (dbg_o[i].state !== ST_IDLE) begin
          errors++;
          $display("FAIL reset_state%0d: got %0d want %0d", i, dbg_o[i].state, ST_IDLE);
        end
      end
      if (pv_o[i]) begin
        checks++;
        if (exp_pay_q.size() == 0) begin
          errors++;
          $display("FAIL payload%0d: unexpected byte %h last=%b, want none", i, pd_o[i], pl_o[i]);
        end else begin
          ep = exp_pay_q.pop_front();
          if ({1'(i), pl_o[i], pd_o[i]} !== ep) begin
            errors++;
            $display("FAIL payload%0d: got inst=%0d last=%b data=%h, want inst=%0d last=%b data=%h",
                     i, i, pl_o[i], pd_o[i], ep[9], ep[8], ep[7:0]);
          end
        end
      end
      if (done_o[i]) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL pkt_done%0d: unexpected pulse err=%0d, want none", i, err_o[i]);
        end else begin
          ed = exp_done_q.pop_front();
          if ({1'(i), err_o[i], src_o[i], len_o[i]} !== ed) begin
            errors++;
            $display("FAIL pkt_done%0d: got inst=%0d err=%0d src=%h len=%h, want inst=%0d err=%0d src=%h len=%h",
                     i, i, err_o[i], src_o[i], len_o[i], ed[35], ed[34:32], ed[31:16], ed[15:0]);
          end
        end
      end
    end
    if (fin) begin
      checks++;
      if (exp_pay_q.size() != 0 || exp_done_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d payload and %0d done entries unseen, want 0 and 0",
                 exp_pay_q.size(), exp_done_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin din[i] = 8'h00; vin[i] = 1'b0; end
    chk_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_rst = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;

    // Good datagram, then a wrong destination port after a 1-cycle gap.
    hdr(16'h1388, 16'h1389, 16'h0013); add_str("Hello World", 11);
    exp_pay(0, "Hello World", 11, 1'b1);
    exp_done(0, ERR_OK, 16'h1388, 16'd19);
    send(0, 1);

    hdr(16'h1388, 16'h1390, 16'h0013); add_str("Hello World", 11);
    exp_done(0, ERR_PORT, 16'h1388, 16'd19);
    send(0, 1);

    // Same datagram on the instance without port checking.
    exp_pay(1, "Hello World", 11, 1'b1);
    exp_done(1, ERR_OK, 16'h1388, 16'd19);
    send(1, 2);

    // Truncated payload.
    hdr(16'h1388, 16'h1389, 16'h0013); add_str("Hello", 5);
    exp_pay(0, "Hello", 5, 1'b0);
    exp_done(0, ERR_TRUNC, 16'h1388, 16'd19);
    send(0, 1);

    // Length below header size; trailing bytes are dropped.
    hdr(16'h1388, 16'h1389, 16'h0007); add_str("xy", 2);
    exp_done(0, ERR_LEN_BAD, 16'h1388, 16'd7);
    send(0, 1);

    // One-byte payload followed by extra bytes.
    hdr(16'h1388, 16'h1389, 16'h0009); add_str("ABC", 3);
    exp_pay(0, "A", 1, 1'b1);
    exp_done(0, ERR_OVERRUN, 16'h1388, 16'd9);
    send(0, 1);

    // Header-only datagram.
    hdr(16'h0035, 16'h1389, 16'h0008);
    exp_done(0, ERR_OK, 16'h0035, 16'd8);
    send(0, 1);

    // Reset while payload byte 4 is on the bus.
    hdr(16'h1388, 16'h1389, 16'h0013); add_str("Hello World", 11);
    exp_pay(0, "Hell", 4, 1'b0);
    for (int i = 0; i < 12; i++) begin
      din[0] = pkt[i]; vin[0] = 1'b1;
      @(posedge clk); #1;
    end
    din[0] = pkt[12];
    @(negedge clk); #1;
    rst_n   = 1'b0;
    chk_rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk_rst = 1'b0;
    rst_n   = 1'b1;
    for (int i = 13; i < 19; i++) begin
      din[0] = pkt[i];
      @(posedge clk); #1;
    end
    vin[0] = 1'b0; din[0] = 8'h00;
    @(posedge clk); #1;

    // Intact datagram after one idle cycle, then a back-to-back pair.
    hdr(16'h1388, 16'h1389, 16'h0013); add_str("Hello World", 11);
    exp_pay(0, "Hello World", 11, 1'b1);
    exp_done(0, ERR_OK, 16'h1388, 16'd19);
    send(0, 1);

    hdr(16'h2000, 16'h1389, 16'h0013); add_str("Hello World", 11);
    exp_pay(0, "Hello World", 11, 1'b1);
    exp_done(0, ERR_OK, 16'h2000, 16'd19);
    send(0, 1);
    hdr(16'h2001, 16'h1389, 16'h0013); add_str("hello world", 11);
    exp_pay(0, "hello world", 11, 1'b1);
    exp_done(0, ERR_OK, 16'h2001, 16'd19);
    send(0, 1);

    repeat (5) @(posedge clk);
    #1;
    fin = 1'b1;
  end

endmodule
